pattern_step_counter: RTL and testbench
=======================================

# pattern_step_counter

Parametrised step counter for the Patterns datapath and the successor to the fixed 12-bit deltaX adder. It loads a start coordinate and a limit, then advances by a mode-selected step on every enabled cycle. At the limit it either wraps to the start or saturates and stops. It drives pattern coordinate generation, so downstream logic sees a registered coordinate, a one-cycle wrap pulse and a level done flag.

## Interface
- WIDTH, 12, bit width of coordinate, start, limit and output
- STEP1, 1, step size for xmode=2'b01 (xmode=2'b00 is always step 0)
- STEP2, 4, step size for xmode=2'b10
- STEP3, 8, step size for xmode=2'b11
- WRAP_EN, 1, 1 = wrap to start at limit; 0 = saturate at limit and enter DONE
- clk  input  1  master clock, all state on rising edge
- rst_n  input  1  asynchronous, active-high reset (1 = reset asserted)
- clear  input  1  synchronous return to IDLE, highest synchronous priority
- load  input  1  capture start_val/limit_val and enter RUN
- start_val  input  WIDTH  start coordinate, sampled on load
- limit_val  input  WIDTH  inclusive upper bound, sampled on load
- cnt_enb  input  1  advance one step this cycle (RUN only)
- xmode  input  2  step select, sampled every enabled cycle
- out  output  WIDTH  current coordinate (registered)
- wrap  output  1  one-cycle pulse on a wrap event
- done  output  1  high while in DONE
- busy  output  1  high while in RUN

## Operation
- States: IDLE (00), RUN (01), DONE (10). Encoding 11 is unreachable and returns to IDLE.
- Reset (rst_n=1, asynchronous): state=IDLE, out=0, start_r=0, limit_r=0, wrap=0, done=0, busy=0.
- Synchronous priority per edge: clear > load > cnt_enb.
- clear in any state: go to IDLE, out=0, wrap=0. start_r and limit_r are kept.
- load in any state: start_r=start_val, limit_r=limit_val, out=start_val, state=RUN. This also restarts from RUN or DONE.
- IDLE: out holds 0. cnt_enb is ignored.
- RUN, cnt_enb=0: all registers hold and wrap=0.
- RUN, cnt_enb=1: compute sum = {1'b0,out} + step(xmode) in WIDTH+1 bits, unsigned.
  - sum <= limit_r: out=sum[WIDTH-1:0].
  - sum > limit_r and WRAP_EN=1: out=start_r, wrap=1, stay in RUN.
  - sum > limit_r and WRAP_EN=0: out=limit_r, go to DONE.
- The (WIDTH+1)-bit compare means natural overflow past 2^WIDTH-1 always counts as exceeding the limit. out never wraps modulo 2^WIDTH.
- xmode=00 (step 0) in RUN: out holds, never wraps, never finishes.
- DONE: out holds limit_r. cnt_enb is ignored. Only load, clear or reset leave DONE.
- start_val > limit_val at load: out=start_val, and the first enabled step triggers the limit rule (wrap to start, or saturate to limit_r and go to DONE).
- Step parameters must fit in WIDTH bits; this is checked by elaboration assertion.

## Timing
- Single clock domain, all outputs registered, no combinational path from input to output.
- load at edge N: out=start_val, busy=1 after edge N.
- cnt_enb at edge N: new out is visible after edge N (1-cycle latency).
- wrap is high for exactly the one cycle after the wrapping edge. Back-to-back wraps give consecutive pulses.
- done and busy follow state with no extra delay. They are mutually exclusive and both low in IDLE.
- rst_n assertion mid-operation clears all outputs immediately, without waiting for clk. The first edge after deassertion sees state IDLE.
- clear and load together: clear wins, state=IDLE, out=0.
- load and cnt_enb together: load wins, out=start_val, no step applied.

## Test plan
- Reset check: assert rst_n mid-RUN with out=0x3A0 -> out=0, busy=0, done=0, wrap=0 immediately, before the next clk edge.
- Wrap mode (WIDTH=12, WRAP_EN=1): load start=0x010, limit=0x01C, xmode=11, cnt_enb held high -> out 0x010, 0x018, then 0x010 with wrap=1 for one cycle; repeats.
- Saturate mode (WRAP_EN=0): load start=0x0FE, limit=0x100, xmode=01 -> out 0x0FF, 0x100, then DONE (done=1, busy=0, out=0x100). Further cnt_enb leaves it unchanged.
- Overflow: load start=0xFFC, limit=0xFFF, xmode=10 -> sum=0x1000 > limit -> out=0xFFC with wrap (WRAP_EN=1) or out=0xFFF with done (WRAP_EN=0). Never 0x000.
- Priority: same cycle load=1, clear=1, cnt_enb=1 -> IDLE, out=0. Next cycle load=1, cnt_enb=1 with start=0x020 -> out=0x020, no step applied.
- Mode/enable: in RUN with xmode=00 for 5 cycles -> out constant, no wrap. cnt_enb=0 for 3 cycles mid-count -> out holds, then resumes from the held value.

Source files
------------

// File: rtl/pattern_step_counter.sv
// Mode-selected coordinate step counter: loads start/limit, advances on enable,
// then wraps to start or saturates into DONE once a step would pass the limit.
module pattern_step_counter #(
   parameter int unsigned WIDTH   = 12,
   parameter int unsigned STEP1   = 1,
   parameter int unsigned STEP2   = 4,
   parameter int unsigned STEP3   = 8,
   parameter bit          WRAP_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] start_val,
   input  logic [WIDTH-1:0] limit_val,
   input  logic             cnt_enb,
   input  logic [1:0]       xmode,
   output logic [WIDTH-1:0] out,
   output logic             wrap,
   output logic             done,
   output logic             busy
);

   localparam logic [63:0] MAX_STEP = (64'd1 << WIDTH) - 64'd1;

   if ((64'(STEP1) > MAX_STEP) || (64'(STEP2) > MAX_STEP) || (64'(STEP3) > MAX_STEP))
   begin : g_step_range_check
      $error("pattern_step_counter: step parameter does not fit in WIDTH bits");
   end

   localparam logic [WIDTH:0] STEP1_X = (WIDTH+1)'(STEP1);
   localparam logic [WIDTH:0] STEP2_X = (WIDTH+1)'(STEP2);
   localparam logic [WIDTH:0] STEP3_X = (WIDTH+1)'(STEP3);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] out_nx;
   logic             wrap_nx;
   logic [WIDTH-1:0] start_r, start_nx;
   logic [WIDTH-1:0] limit_r, limit_nx;
   logic [WIDTH:0]   step_x;
   logic [WIDTH:0]   sum;

   always_comb begin
      step_x = '0;
      case (xmode)
         2'b01:   step_x = STEP1_X;
         2'b10:   step_x = STEP2_X;
         2'b11:   step_x = STEP3_X;
         default: step_x = '0;
      endcase
   end

   // One extra bit so a carry out of WIDTH bits always reads as past the limit.
   assign sum = {1'b0, out} + step_x;

   always_comb begin
      state_nx = state;
      out_nx   = out;
      wrap_nx  = 1'b0;
      start_nx = start_r;
      limit_nx = limit_r;

      if (clear) begin
         state_nx = IDLE;
         out_nx   = '0;
      end else if (load) begin
         state_nx = RUN;
         start_nx = start_val;
         limit_nx = limit_val;
         out_nx   = start_val;
      end else begin
         case (state)
            IDLE: begin
               out_nx = '0;
            end
            RUN: begin
               if (cnt_enb) begin
                  if (sum <= {1'b0, limit_r}) begin
                     out_nx = sum[WIDTH-1:0];
                  end else if (WRAP_EN) begin
                     out_nx  = start_r;
                     wrap_nx = 1'b1;
                  end else begin
                     out_nx   = limit_r;
                     state_nx = DONE;
                  end
               end
            end
            DONE: begin
               out_nx = limit_r;
            end
            default: begin
               state_nx = IDLE;
               out_nx   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state   <= IDLE;
         out     <= '0;
         wrap    <= 1'b0;
         start_r <= '0;
         limit_r <= '0;
      end else begin
         state   <= state_nx;
         out     <= out_nx;
         wrap    <= wrap_nx;
         start_r <= start_nx;
         limit_r <= limit_nx;
      end
   end

   assign done = (state == DONE);
   assign busy = (state == RUN);

endmodule

// File: tb/tb_pattern_step_counter.sv
// Randomized plus directed bench for pattern_step_counter, running a wrapping and a
// saturating instance side by side against a behavioural model.
module tb_pattern_step_counter;

   localparam int unsigned W = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          clear = 1'b0;
   logic          load = 1'b0;
   logic [W-1:0]  start_val = '0;
   logic [W-1:0]  limit_val = '0;
   logic          cnt_enb = 1'b0;
   logic [1:0]    xmode = 2'b00;

   logic [W-1:0]  out_s, out_w;
   logic          wrap_s, wrap_w, done_s, done_w, busy_s, busy_w;

   int unsigned   errors = 0;
   int unsigned   checks = 0;

   // Model: index 0 = saturating instance, index 1 = wrapping instance.
   // phase: 0 idle, 1 running, 2 finished.
   int unsigned   m_out[2], m_start[2], m_limit[2], m_phase[2];
   bit            m_wrap[2];
   int unsigned   steps[4] = '{0, 1, 4, 8};

   always #5 clk = ~clk;

   pattern_step_counter #(.WIDTH(W), .STEP1(1), .STEP2(4), .STEP3(8), .WRAP_EN(1'b0)) dut_sat (
      .clk(clk), .rst_n(rst_n), .clear(clear), .load(load),
      .start_val(start_val), .limit_val(limit_val), .cnt_enb(cnt_enb), .xmode(xmode),
      .out(out_s), .wrap(wrap_s), .done(done_s), .busy(busy_s)
   );

   pattern_step_counter #(.WIDTH(W), .STEP1(1), .STEP2(4), .STEP3(8), .WRAP_EN(1'b1)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .clear(clear), .load(load),
      .start_val(start_val), .limit_val(limit_val), .cnt_enb(cnt_enb), .xmode(xmode),
      .out(out_w), .wrap(wrap_w), .done(done_w), .busy(busy_w)
   );

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_out[i] = 0; m_start[i] = 0; m_limit[i] = 0; m_phase[i] = 0; m_wrap[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      int unsigned s;
      for (int i = 0; i < 2; i++) begin
         m_wrap[i] = 1'b0;
         if (clear) begin
            m_phase[i] = 0; m_out[i] = 0;
         end else if (load) begin
            m_start[i] = start_val; m_limit[i] = limit_val;
            m_out[i] = start_val; m_phase[i] = 1;
         end else if (m_phase[i] == 1 && cnt_enb) begin
            s = m_out[i] + steps[xmode];
            if (s <= m_limit[i]) m_out[i] = s;
            else if (i == 1) begin
               m_out[i] = m_start[i]; m_wrap[i] = 1'b1;
            end else begin
               m_out[i] = m_limit[i]; m_phase[i] = 2;
            end
         end
      end
   endtask

   task automatic compare_all();
      check("sat_out",   out_s,  m_out[0]);
      check("sat_wrap",  wrap_s, m_wrap[0]);
      check("sat_done",  done_s, m_phase[0] == 2);
      check("sat_busy",  busy_s, m_phase[0] == 1);
      check("wrap_out",  out_w,  m_out[1]);
      check("wrap_wrap", wrap_w, m_wrap[1]);
      check("wrap_done", done_w, m_phase[1] == 2);
      check("wrap_busy", busy_w, m_phase[1] == 1);
   endtask

   // Apply inputs for one edge, advance the model, then compare 1 ns after the edge.
   task automatic cyc(input bit c, input bit l, input int unsigned sv, input int unsigned lv,
                      input bit e, input int unsigned xm);
      clear = c; load = l; start_val = W'(sv); limit_val = W'(lv);
      cnt_enb = e; xmode = 2'(xm);
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   initial begin
      model_reset();
      #12;
      check("rst_out",  out_w,  0);
      check("rst_busy", busy_w, 0);
      check("rst_done", done_s, 0);
      #10 rst_n = 1'b0;   // released at t=22, between edges

      // Asynchronous reset mid-run
      cyc(0, 1, 'h3A0, 'hFFF, 0, 0);
      check("pre_rst_out", out_w, 'h3A0);
      #2 rst_n = 1'b1;
      #1;
      model_reset();
      check("async_out",  out_w,  0);
      check("async_busy", busy_w, 0);
      check("async_done", done_w, 0);
      check("async_wrap", wrap_w, 0);
      check("async_sout", out_s,  0);
      #2 rst_n = 1'b0;
      cyc(0, 0, 0, 0, 1, 3);
      check("idle_after_rst", out_w, 0);

      // Wrap sequence with step 8
      cyc(0, 1, 'h010, 'h01C, 1, 3);
      check("wseq0", out_w, 'h010);
      cyc(0, 0, 0, 0, 1, 3);
      check("wseq1", out_w, 'h018);
      cyc(0, 0, 0, 0, 1, 3);
      check("wseq2", out_w, 'h010);
      check("wseq2_pulse", wrap_w, 1);
      check("sseq2_sat", out_s, 'h01C);
      cyc(0, 0, 0, 0, 1, 3);
      check("wseq3_pulse_end", wrap_w, 0);
      cyc(0, 0, 0, 0, 1, 3);

      // Saturate sequence with step 1
      cyc(0, 1, 'h0FE, 'h100, 1, 1);
      cyc(0, 0, 0, 0, 1, 1);
      check("sseq1", out_s, 'h0FF);
      cyc(0, 0, 0, 0, 1, 1);
      check("sseq2", out_s, 'h100);
      cyc(0, 0, 0, 0, 1, 1);
      check("sseq_done", done_s, 1);
      check("sseq_out", out_s, 'h100);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 3);
      check("sseq_hold", out_s, 'h100);

      // Overflow past 2^W-1
      cyc(0, 1, 'hFFC, 'hFFF, 1, 2);
      cyc(0, 0, 0, 0, 1, 2);
      check("ovf_wrap_out", out_w, 'hFFC);
      check("ovf_wrap_pulse", wrap_w, 1);
      check("ovf_sat_out", out_s, 'hFFF);
      check("ovf_sat_done", done_s, 1);

      // Priority
      cyc(1, 1, 'h055, 'h0FF, 1, 1);
      check("prio_clear", out_w, 0);
      check("prio_clear_busy", busy_w, 0);
      cyc(0, 1, 'h020, 'h0FF, 1, 1);
      check("prio_load", out_w, 'h020);

      // Step 0 and enable gaps
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0);
      check("x00_hold", out_w, 'h020);
      cyc(0, 0, 0, 0, 1, 2);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 3);
      check("enb_hold", out_w, 'h024);
      cyc(0, 0, 0, 0, 1, 2);
      check("enb_resume", out_w, 'h028);

      // start > limit at load
      cyc(0, 1, 'h080, 'h040, 0, 1);
      cyc(0, 0, 0, 0, 1, 1);
      check("inv_wrap", out_w, 'h080);
      check("inv_sat", out_s, 'h040);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int unsigned r, sv, lv;
         r  = $urandom_range(0, 99);
         sv = $urandom_range(0, 4095);
         if ($urandom_range(0, 3) == 0) lv = $urandom_range(0, 4095);
         else lv = (sv + $urandom_range(0, 48) > 4095) ? 4095 : sv + $urandom_range(0, 48);
         cyc(r < 3, (r >= 3 && r < 12) || $urandom_range(0, 49) == 0, sv, lv,
             $urandom_range(0, 9) < 7, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
